// File: rtl/ofdm_clk_en_gen_pkg.sv
// Shared defaults and helpers for the OFDM clock-enable generator.
// The divide-ratio helper maps a zero ratio onto divide-by-one.
package ofdm_clk_pkg;

    localparam int DIV_W_DEF       = 8;
    localparam int LOCK_CYCLES_DEF = 10;
    localparam int EFF_W           = 16;

    function automatic logic [EFF_W-1:0] eff_ratio(input logic [EFF_W-1:0] r);
        return (r == '0) ? EFF_W'(1) : r;
    endfunction

endpackage

// File: rtl/ofdm_clk_en_gen_if.sv
// Configuration and status bundle for ofdm_clk_en_gen.
// The master drives the ratios, cascade mask and load strobe. The slave returns the enables and the lock.
interface ofdm_clk_en_gen_if
    import ofdm_clk_pkg::*;
#(
    parameter int NUM_CH = 7,
    parameter int DIV_W  = DIV_W_DEF
);
    logic [NUM_CH*DIV_W-1:0] div_ratio;
    logic [NUM_CH-1:0]       cascade;
    logic                    cfg_load;
    logic [NUM_CH-1:0]       outclk_en;
    logic [NUM_CH-1:0]       outclk;
    logic                    locked;

    modport master (
        output div_ratio, cascade, cfg_load,
        input  outclk_en, outclk, locked
    );

    modport slave (
        input  div_ratio, cascade, cfg_load,
        output outclk_en, outclk, locked
    );
endinterface

// File: rtl/ofdm_clk_en_gen_clk_div_ch.sv
// One divider channel. The ratio register is a shadow copy loaded on restart.
// The counter advances on source ticks, and the tick output is combinational so that cascades add no latency.
module clk_div_ch
    import ofdm_clk_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             refclk,
    input  logic             restart,
    input  logic             src,
    input  logic [DIV_W-1:0] ratio_in,
    output logic             tick,
    output logic             outclk,
    output logic             outclk_en,
    output logic             seen
);
    logic [DIV_W-1:0] ratio_q;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] r_eff;
    logic             outclk_q, outclk_d;
    logic             outclk_en_q, outclk_en_d;
    logic             seen_q, seen_d;

    always_comb begin
        r_eff       = DIV_W'(eff_ratio(EFF_W'(ratio_q)));
        tick        = src && (cnt_q == r_eff - DIV_W'(1));
        cnt_d       = cnt_q;
        if (src) begin
            cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
        end
        outclk_en_d = tick;
        outclk_d    = outclk_q ^ tick;
        seen_d      = seen_q | tick;
    end

    // A restart reloads the ratio and aborts any partial period, so the outputs stay glitch-free.
    always_ff @(posedge refclk) begin
        if (restart) begin
            ratio_q     <= ratio_in;
            cnt_q       <= '0;
            outclk_q    <= 1'b0;
            outclk_en_q <= 1'b0;
            seen_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            outclk_q    <= outclk_d;
            outclk_en_q <= outclk_en_d;
            seen_q      <= seen_d;
        end
    end

    assign outclk    = outclk_q;
    assign outclk_en = outclk_en_q;
    assign seen      = seen_q;
endmodule

// File: rtl/ofdm_clk_en_gen.sv
// Multi-channel clock-enable generator. Each channel divides refclk or the previous channel's tick.
// locked asserts once every channel has ticked and the settle window has elapsed.
module ofdm_clk_en_gen
    import ofdm_clk_pkg::*;
#(
    parameter int NUM_CH      = 7,
    parameter int DIV_W       = DIV_W_DEF,
    parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
    input  logic                refclk,
    input  logic                rst,
    ofdm_clk_en_gen_if.slave    bus
);
    localparam int LW = $clog2(LOCK_CYCLES + 1);

    logic              restart;
    logic [NUM_CH-1:0] seen;
    logic [LW-1:0]     lock_cnt_q, lock_cnt_d;
    logic              locked_q, locked_d;

    assign restart = rst | bus.cfg_load;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic src;
        logic tick;

        if (gi == 0) begin : g_root
            assign src = 1'b1;
        end else begin : g_casc
            logic casc_q;

            always_ff @(posedge refclk) begin
                if (restart) begin
                    casc_q <= bus.cascade[gi];
                end
            end

            // Ticks chain combinationally, so a cascaded channel divides by the product of the ratios along the chain.
            assign src = casc_q ? g_ch[gi-1].tick : 1'b1;
        end

        clk_div_ch #(.DIV_W(DIV_W)) u_ch (
            .refclk    (refclk),
            .restart   (restart),
            .src       (src),
            .ratio_in  (bus.div_ratio[gi*DIV_W +: DIV_W]),
            .tick      (tick),
            .outclk    (bus.outclk[gi]),
            .outclk_en (bus.outclk_en[gi]),
            .seen      (seen[gi])
        );
    end

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (lock_cnt_q != LW'(LOCK_CYCLES)) begin
            lock_cnt_d = lock_cnt_q + LW'(1);
        end
        locked_d = locked_q | ((lock_cnt_q == LW'(LOCK_CYCLES)) && (&seen));
    end

    always_ff @(posedge refclk) begin
        if (restart) begin
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign bus.locked = locked_q;
endmodule

// File: tb/tb_ofdm_clk_en_gen.sv
// Directed bench for ofdm_clk_en_gen. The expected outputs come from a closed-form period model.
// Each expectation is queued when a cycle is driven and is checked after the edge.
module tb_ofdm_clk_en_gen;
    localparam int NUM_CH = 7;
    localparam int DIV_W  = 8;
    localparam int LOCK   = 10;

    typedef struct packed {
        logic [NUM_CH-1:0] en;
        logic [NUM_CH-1:0] oc;
        logic              lk;
    } exp_t;

    logic refclk = 1'b0;
    logic rst;
    always #5 refclk = ~refclk;

    ofdm_clk_en_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

    ofdm_clk_en_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_CYCLES(LOCK)) dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus)
    );

    exp_t        sb[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          n           = 0;
    int unsigned cfg_r[NUM_CH];
    bit [NUM_CH-1:0] cfg_c;

    // Channel i pulses after each edge E_n with n % P_i == 0. P_i is its effective period.
    // outclk is the parity of the ticks so far.
    function automatic exp_t predict(input int cyc);
        exp_t   e;
        longint p[NUM_CH];
        longint pmax = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            longint r = (cfg_r[i] == 0) ? 1 : longint'(cfg_r[i]);
            p[i] = (i > 0 && cfg_c[i]) ? p[i-1] * r : r;
            if (p[i] > pmax) pmax = p[i];
        end
        for (int i = 0; i < NUM_CH; i++) begin
            e.en[i] = (cyc >= 1) && ((cyc % p[i]) == 0);
            e.oc[i] = ((cyc / p[i]) % 2) == 1;
        end
        e.lk = (cyc >= LOCK + 1) && (cyc >= pmax + 1);
        return e;
    endfunction

    task automatic tick_cycle(input string tag);
        exp_t exp_v;
        exp_t obs;
        if (rst || bus.cfg_load) begin
            for (int i = 0; i < NUM_CH; i++) cfg_r[i] = bus.div_ratio[i*DIV_W +: DIV_W];
            cfg_c = bus.cascade;
            n = 0;
        end else begin
            n++;
        end
        sb.push_back(predict(n));
        @(posedge refclk);
        #1;
        exp_v = sb.pop_front();
        obs   = {bus.outclk_en, bus.outclk, bus.locked};
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s n=%0d observed en=%b oc=%b lk=%b expected en=%b oc=%b lk=%b",
                   tag, n, obs.en, obs.oc, obs.lk, exp_v.en, exp_v.oc, exp_v.lk);
        end
    endtask

    task automatic run(input int cycles, input string tag);
        repeat (cycles) tick_cycle(tag);
        $display("step %s: %0d cycles, n=%0d, locked=%b", tag, cycles, n, bus.locked);
    endtask

    task automatic set_all(input int r);
        for (int i = 0; i < NUM_CH; i++) bus.div_ratio[i*DIV_W +: DIV_W] = DIV_W'(r);
    endtask

    task automatic load(input string tag);
        bus.cfg_load = 1'b1;
        run(1, tag);
        bus.cfg_load = 1'b0;
    endtask

    initial begin
        // Reset, ratio 2 everywhere, no cascade
        set_all(2);
        bus.cascade  = '0;
        bus.cfg_load = 1'b0;
        rst          = 1'b1;
        run(10, "t1_reset");
        rst = 1'b0;
        run(20, "t1_ratio2");

        // Full cascade chain of divide-by-2
        bus.cascade = 7'b1111110;
        load("t2_load");
        run(270, "t2_cascade");

        // Ratio 0 and 1 behave as divide-by-one, ratio 3 on ch2
        bus.cascade = '0;
        set_all(2);
        bus.div_ratio[0*DIV_W +: DIV_W] = 8'd0;
        bus.div_ratio[1*DIV_W +: DIV_W] = 8'd1;
        bus.div_ratio[2*DIV_W +: DIV_W] = 8'd3;
        load("t3_load");
        run(30, "t3_ratio013");

        // Ratio 4, then reload with ratio 3 mid-period (cnt_0 == 2 at n=14)
        set_all(4);
        load("t4_load4");
        run(14, "t4_ratio4");
        set_all(3);
        load("t4_load3");
        run(20, "t4_ratio3");

        // Single-cycle rst adopts a new ratio without cfg_load
        set_all(2);
        load("t5_load");
        run(15, "t5_ratio2");
        set_all(5);
        rst = 1'b1;
        run(1, "t5_rst");
        rst = 1'b0;
        run(25, "t5_ratio5");

        // Max ratio on ch0. Live input churn must not disturb timing.
        set_all(2);
        bus.div_ratio[0*DIV_W +: DIV_W] = 8'd255;
        bus.cascade = '0;
        load("t6_load");
        for (int k = 0; k < 1025; k++) begin
            bus.div_ratio = {$urandom, $urandom};
            bus.cascade   = NUM_CH'($urandom);
            tick_cycle("t6_ratio255");
        end
        $display("step t6_ratio255: 1025 cycles, n=%0d, locked=%b", n, bus.locked);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ofdm_clk_en_gen.md
Name: ofdm_clk_en_gen

Overview:
Multi-channel programmable clock-enable generator for the OFDM datapath. It replaces chains of fixed PLL instances with a single refclk domain plus per-channel divided enables. Each channel divides either refclk or the previous channel's tick, so the cascaded PLL chain topology is kept. A lock indication tells downstream FFT/IFFT logic when all rates are valid.

Parameters:
NUM_CH, 7, number of output channels (1..16)
DIV_W, 8, width of each divide ratio field
LOCK_CYCLES, 10, minimum refclk cycles after restart before locked may assert (>=1)

Ports:
refclk  input  1  sole clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
div_ratio  input  NUM_CH*DIV_W  channel i ratio R_i at [i*DIV_W +: DIV_W]; 0 treated as 1
cascade  input  NUM_CH  bit i=1: channel i counts channel i-1 ticks; bit 0 ignored
cfg_load  input  1  one-cycle strobe: adopt new div_ratio/cascade, restart all channels aligned
outclk_en  output  NUM_CH  registered one-refclk-cycle enable pulse per channel tick
outclk  output  NUM_CH  registered square wave; toggles on each channel tick (period 2*R_i source ticks, exact 50% duty)
locked  output  1  all channels running with current configuration

Behaviour:
- Shadow registers: ratio_q[i] and casc_q[i] load from div_ratio/cascade on any edge with rst=1 or cfg_load=1. Otherwise they hold, so live input changes have no effect.
- Restart (rst=1, or cfg_load=1; rst has priority, same result) clears: cnt_i=0, outclk=0, outclk_en=0, seen_i=0, lock_cnt=0, locked=0. These are also the reset values of every output.
- Source tick: s_0=1. For i>0, s_i = casc_q[i] ? tick_{i-1} : 1.
- Per-channel tick (combinational): tick_i = s_i && (cnt_i == R_i-1), with R_i = max(ratio_q[i],1).
- Counter: if s_i, cnt_i <= tick_i ? 0 : cnt_i+1. Otherwise cnt_i holds.
- Ticks chain combinationally, so cascading adds no per-stage latency. The effective division of a cascaded channel is the product of the ratios down the chain.
- Registered outputs: outclk_en_i <= tick_i. outclk_i <= outclk_i ^ tick_i.
- Latency: counting the first non-restart edge as E1, outclk_en_i first goes high after edge E_R (non-cascaded). It then pulses every R_i cycles.
- R_i=1, non-cascaded: outclk_en_i is constant 1 from E1, and outclk_i toggles every cycle.
- seen_i sets on the first tick_i after a restart and holds.
- lock_cnt increments each non-restart cycle and saturates at LOCK_CYCLES; its width is clog2(LOCK_CYCLES+1).
- locked <= (lock_cnt == LOCK_CYCLES) && (&seen). Once set, it holds until the next restart.
- Counter width is DIV_W. Ratio 2^DIV_W-1 is the maximum, and no overflow is possible.
- cfg_load during operation aborts any partial period. There is no glitch: outputs are zero on the following cycle, then behave as after reset.

Decomposition:
- Package ofdm_clk_pkg: DIV_W default, LOCK_CYCLES default, and a function eff_ratio(r) returning max(r,1).
- Sub-module clk_div_ch, one channel: shadow ratio, counter, tick, outclk/outclk_en registers, seen flag. Inputs are s_i and restart; it exports tick_i. It is instantiated NUM_CH times in a generate loop, with the cascade mux in the top.
- The top holds the cascade muxing, lock_cnt and the locked logic.

Test Plan:
1. All ratios 2, cascade=0, rst high 10 cycles then low -> every outclk_en first pulses after E2, then every 2 cycles. Every outclk has period 4. locked rises after E11 (lock_cnt reaches 10 at E10, registered at E11).
2. All ratios 2, cascade=7'b1111110 -> channel k outclk_en period 2^(k+1). outclk_en[6] first pulses after E128. locked rises after E129.
3. ratio[0]=0, ratio[1]=1, cascade=0 -> outclk_en[0] and outclk_en[1] constant 1 from E1, outclk[0] and outclk[1] toggle every cycle. Ratio 3 on ch2 -> pulse every 3 cycles, outclk period 6.
4. Ratio 4 running, cfg_load with ratio 3 while cnt_0=2 -> next cycle all outclk_en=0, outclk=0, locked=0. First ch0 pulse 3 cycles later; locked reasserts after LOCK_CYCLES.
5. One-cycle rst mid-run with div_ratio changed to 5 -> outputs cleared next cycle. Ratio 5 is adopted with no cfg_load, and pulses every 5 cycles.
6. Ratio 255 on ch0, cascade=0 -> pulse every 255 cycles with no wrap error over 4 periods. Toggling div_ratio without cfg_load -> no change in output timing.
